control_unit: RTL and testbench

Multicycle control unit for the RISC-V core: the counterpart of the datapath, consuming its `opcode`, `funct3` and `alu_flags` and driving every datapath control strobe. A four-phase FSM (FETCH, DECODE, EXECUTE, WRITEBACK) matches the datapath's one-instruction-per-four-clocks PC update and issues `pc_en` at the end of each instruction. It also keeps a retired-instruction counter for bring-up.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/control_unit_if.sv | 29 ++
 rtl/control_unit_branch_eval.sv | 23 ++
 rtl/control_unit.sv | 127 ++++++++++++
 tb/tb_control_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the multicycle RISC-V control path:
// opcode classes, ALU command codes, branch funct3 codes and FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_ILLEGAL,
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH
    } iclass_e;

    function automatic iclass_e classify(input logic [6:0] op);
        case (op)
            OP_R:      return CL_R;
            OP_I:      return CL_I;
            OP_LOAD:   return CL_LOAD;
            OP_STORE:  return CL_STORE;
            OP_BRANCH: return CL_BRANCH;
            default:   return CL_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface control_unit_if #(
    parameter int INSTRET_BITS = 32
);
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [3:0]              alu_flags;
    logic                    d_mem_we;
    logic                    rf_we;
    logic [3:0]              alu_cmd;
    logic                    alu_src;
    logic                    pc_src;
    logic                    rf_src;
    logic                    pc_en;
    logic                    illegal;
    logic [INSTRET_BITS-1:0] instret;

    modport master (
        input  opcode, funct3, alu_flags,
        output d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_en,
               illegal, instret
    );

    modport slave (
        output opcode, funct3, alu_flags,
        input  d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_en,
               illegal, instret
    );
endinterface

// File: rtl/control_unit_branch_eval.sv
// Branch condition evaluation: funct3 + ALU flags -> taken.
// Flags: [0] equal, [1] not_equal, [2] less (signed), [3] greater (signed).
module branch_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [3:0] alu_flags_i,
    output logic       taken_o
);

    // Select the flag (or its complement) matching the branch kind.
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = alu_flags_i[0];
            F3_BNE:  taken_o = alu_flags_i[1];
            F3_BLT:  taken_o = alu_flags_i[2];
            F3_BGE:  taken_o = ~alu_flags_i[2];
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/WRITEBACK, one instruction
// per four clocks, plus a retired-instruction counter.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the FSM.
//
// state        | meaning
// ST_FETCH     | idle phase, all strobes low
// ST_DECODE    | opcode/funct3 latched at the end of this phase
// ST_EXECUTE   | alu_cmd/alu_src driven, branch taken sampled at end
// ST_WRITEBACK | write strobes, pc_en, pc_src; instret counts
// ST_HALT      | trap on illegal opcode (macro build only), wait for reset
module control_unit
    import riscv_pkg::*;
#(
    parameter int WORDSIZE     = 64,
    parameter int INSTRET_BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    control_unit_if.master  bus
);

    generate
        if (WORDSIZE < 1) begin : g_wordsize_check
            $error("WORDSIZE must be positive");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [6:0]              opcode_q, opcode_d;
    logic [2:0]              funct3_q, funct3_d;
    logic                    taken_q, taken_d;
    logic [INSTRET_BITS-1:0] instret_q, instret_d;
    logic                    br_taken;
    iclass_e                 cls;

    assign cls = classify(opcode_q);

    branch_eval u_branch_eval (
        .funct3_i    (funct3_q),
        .alu_flags_i (bus.alu_flags),
        .taken_o     (br_taken)
    );

    // State, latched instruction fields, taken flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 7'b0000000;
            funct3_q  <= 3'b000;
            taken_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic and output decode from registered state only.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        funct3_d     = funct3_q;
        taken_d      = taken_q;
        instret_d    = instret_q;
        bus.d_mem_we = 1'b0;
        bus.rf_we    = 1'b0;
        bus.alu_cmd  = 4'b0000;
        bus.alu_src  = 1'b0;
        bus.pc_src   = 1'b0;
        bus.rf_src   = 1'b0;
        bus.pc_en    = 1'b0;
        bus.illegal  = 1'b0;

        if (state_q == ST_EXECUTE || state_q == ST_WRITEBACK) begin
            case (cls)
                CL_R:      bus.alu_cmd = ALU_FUNCT;
                CL_I:      begin bus.alu_cmd = ALU_FUNCT; bus.alu_src = 1'b1; end
                CL_LOAD:   begin bus.alu_cmd = ALU_ADD;   bus.alu_src = 1'b1; end
                CL_STORE:  begin bus.alu_cmd = ALU_ADD;   bus.alu_src = 1'b1; end
                CL_BRANCH: bus.alu_cmd = ALU_SUB;
                default:   bus.alu_cmd = 4'b0000;
            endcase
        end

        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                state_d  = ST_EXECUTE;
                opcode_d = bus.opcode;
                funct3_d = bus.funct3;
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
                taken_d = (cls == CL_BRANCH) && br_taken;
            end
            ST_WRITEBACK: begin
                bus.rf_we    = (cls == CL_R) || (cls == CL_I) || (cls == CL_LOAD);
                bus.rf_src   = (cls == CL_LOAD);
                bus.d_mem_we = (cls == CL_STORE);
                bus.pc_src   = taken_q;
                bus.pc_en    = 1'b1;
                state_d      = ST_FETCH;
                instret_d    = instret_q + INSTRET_BITS'(1);
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (cls == CL_ILLEGAL) begin
                    bus.illegal = 1'b1;
                    state_d     = ST_HALT;
                    instret_d   = instret_q;
                end
`endif
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT: begin
                bus.illegal = 1'b1;
                state_d     = ST_HALT;
            end
`endif
            default: state_d = ST_FETCH;
        endcase

        bus.instret = instret_q;
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   exp_instret = 0;

    control_unit_if #(.INSTRET_BITS(32)) bus ();

    control_unit #(.WORDSIZE(64), .INSTRET_BITS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] flags;
        logic [6:0] op_late;
        logic [3:0] acmd;
        logic       asrc;
        logic       rfwe;
        logic       memwe;
        logic       rfsrc;
        logic       pcsrc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // {d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_en}
    function automatic logic [9:0] outs();
        return {bus.d_mem_we, bus.rf_we, bus.alu_cmd, bus.alu_src,
                bus.pc_src, bus.rf_src, bus.pc_en};
    endfunction

    // Called at the negedge of a FETCH cycle; returns at the next FETCH.
    task automatic do_instr(input vec_t v, input string tag);
        bus.opcode    = v.op;
        bus.funct3    = v.f3;
        bus.alu_flags = v.flags;
        chk({tag, "_fetch_idle"}, 32'(outs()), 32'h0);
        chk({tag, "_instret"}, bus.instret, 32'(exp_instret));
        @(negedge clk);
        chk({tag, "_decode_idle"}, 32'(outs()), 32'h0);
        @(negedge clk);
        chk({tag, "_exec"}, 32'(outs()), 32'({2'b00, v.acmd, v.asrc, 3'b000}));
        bus.opcode = v.op_late;
        @(negedge clk);
        chk({tag, "_wb"}, 32'(outs()),
            32'({v.memwe, v.rfwe, v.acmd, v.asrc, v.pcsrc, v.rfsrc, 1'b1}));
        chk({tag, "_wb_illegal"}, 32'(bus.illegal), 32'h0);
        bus.alu_flags = ~v.flags;
        #1;
        chk({tag, "_wb_pcsrc_hold"}, 32'(bus.pc_src), 32'(v.pcsrc));
        exp_instret++;
        @(negedge clk);
    endtask

    initial begin
        int   first;
        vec_t v;
        //            op          f3      flags    op_late     acmd  as rw mw rs ps
        vecs[0]  = '{7'b0110011, 3'b000, 4'b0000, 7'b0110011, 4'h2, 0, 1, 0, 0, 0};
        vecs[1]  = '{7'b0110011, 3'b000, 4'b0000, 7'b0110011, 4'h2, 0, 1, 0, 0, 0};
        vecs[2]  = '{7'b0000011, 3'b011, 4'b0000, 7'b0000011, 4'h0, 1, 1, 0, 1, 0};
        vecs[3]  = '{7'b0100011, 3'b011, 4'b0000, 7'b0100011, 4'h0, 1, 0, 1, 0, 0};
        vecs[4]  = '{7'b1100011, 3'b001, 4'b0010, 7'b1100011, 4'h1, 0, 0, 0, 0, 1};
        vecs[5]  = '{7'b1100011, 3'b001, 4'b0001, 7'b1100011, 4'h1, 0, 0, 0, 0, 0};
        vecs[6]  = '{7'b1100011, 3'b000, 4'b0001, 7'b1100011, 4'h1, 0, 0, 0, 0, 1};
        vecs[7]  = '{7'b1100011, 3'b100, 4'b0100, 7'b1100011, 4'h1, 0, 0, 0, 0, 1};
        vecs[8]  = '{7'b1100011, 3'b101, 4'b0100, 7'b1100011, 4'h1, 0, 0, 0, 0, 0};
        vecs[9]  = '{7'b1100011, 3'b101, 4'b0000, 7'b1100011, 4'h1, 0, 0, 0, 0, 1};
        vecs[10] = '{7'b1100011, 3'b010, 4'b1111, 7'b1100011, 4'h1, 0, 0, 0, 0, 0};
        vecs[11] = '{7'b0010011, 3'b000, 4'b1111, 7'b0010011, 4'h2, 1, 1, 0, 0, 0};
        vecs[12] = '{7'b0110011, 3'b000, 4'b0000, 7'b0100011, 4'h2, 0, 1, 0, 0, 0};
        vecs[13] = '{7'b0110011, 3'b001, 4'b0010, 7'b0110011, 4'h2, 0, 1, 0, 0, 0};

        rst_n         = 1'b0;
        bus.opcode    = 7'b0;
        bus.funct3    = 3'b0;
        bus.alu_flags = 4'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_instret", bus.instret, 32'h0);
        chk("reset_illegal", 32'(bus.illegal), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            do_instr(vecs[i], $sformatf("v%0d", i));

        // Reset dropped in WRITEBACK of a store.
        bus.opcode = 7'b0100011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_store_wb_memwe", 32'(bus.d_mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_store_memwe_drop", 32'(bus.d_mem_we), 32'h0);
        chk("rst_store_pcen_drop", 32'(bus.pc_en), 32'h0);
        chk("rst_store_instret", bus.instret, 32'h0);
        exp_instret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.pc_en) begin
                first = k;
                break;
            end
        end
        chk("rst_first_pc_en", 32'(first), 32'h3);
        exp_instret = 1;
        @(negedge clk);

        // Unsupported opcode.
        v = '{7'b1111111, 3'b000, 4'b0000, 7'b1111111, 4'h0, 0, 0, 0, 0, 0};
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.opcode = v.op;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("ill_wb_illegal", 32'(bus.illegal), 32'h1);
        chk("ill_wb_strobes", 32'({bus.rf_we, bus.d_mem_we, bus.pc_src}), 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("ill_halt_pcen", 32'(bus.pc_en), 32'h0);
            chk("ill_halt_illegal", 32'(bus.illegal), 32'h1);
        end
        chk("ill_halt_instret", bus.instret, 32'(exp_instret));
`else
        do_instr(v, "ill");
        do_instr(vecs[0], "after_ill");
        chk("after_ill_instret", bus.instret, 32'(exp_instret));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
